// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline datapath (master) and the hazard controller (slave).
// Carries the ID/EX/MEM/WB hazard sources and the stall/flush/enable controls back to the pipeline.
interface pipeline_hazard_ctrl_if;
   logic [4:0]  id_rs;
   logic [4:0]  id_rt;
   logic        id_uses_rt;
   logic        ex_mem_read;
   logic [4:0]  ex_dst;
   logic        ex_branch_taken;
   logic        mem_req;
   logic        cache_ready;
   logic        halt_in;
   logic        pipe_stall;
   logic        pc_write_en;
   logic        if_id_write_en;
   logic        id_ex_bubble;
   logic        flush_if_id;
   logic        halted;
   logic        mem_timeout;
   logic [15:0] stall_cycles;

   modport master (
      output id_rs, id_rt, id_uses_rt, ex_mem_read, ex_dst, ex_branch_taken,
             mem_req, cache_ready, halt_in,
      input  pipe_stall, pc_write_en, if_id_write_en, id_ex_bubble, flush_if_id,
             halted, mem_timeout, stall_cycles
   );

   modport slave (
      input  id_rs, id_rt, id_uses_rt, ex_mem_read, ex_dst, ex_branch_taken,
             mem_req, cache_ready, halt_in,
      output pipe_stall, pc_write_en, if_id_write_en, id_ex_bubble, flush_if_id,
             halted, mem_timeout, stall_cycles
   );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: cache-miss stall, branch flush, load-use bubble and halt,
// with a sticky cache-wait timeout flag and a saturating lost-cycle counter.
module pipeline_hazard_ctrl (
   input  logic                    clk,
   input  logic                    reset,
   pipeline_hazard_ctrl_if.slave   hz
);
   localparam int unsigned WAIT_W  = 8;
   localparam int unsigned STALL_W = 16;
   localparam logic [WAIT_W-1:0]  WAIT_MAX  = '1;
   localparam logic [STALL_W-1:0] STALL_MAX = '1;

   typedef enum logic [1:0] {RUN, MEM_WAIT, HALTED} state_e;

   state_e               state_q, state_d;
   logic [WAIT_W-1:0]    wait_cnt_q, wait_cnt_d;
   logic                 halted_q, halted_d;
   logic                 mem_timeout_q, mem_timeout_d;
   logic [STALL_W-1:0]   stall_cycles_q, stall_cycles_d;

   logic mem_miss_c, load_use_c;
   logic pipe_stall_c, pc_write_en_c, if_id_write_en_c, id_ex_bubble_c, flush_if_id_c;

   // Hazard detection and prioritised pipeline controls.
   always_comb begin
      mem_miss_c       = hz.mem_req & ~hz.cache_ready;
      load_use_c       = hz.ex_mem_read & (hz.ex_dst != 5'd0) &
                         ((hz.ex_dst == hz.id_rs) | (hz.id_uses_rt & (hz.ex_dst == hz.id_rt)));
      pipe_stall_c     = (state_q == HALTED) | mem_miss_c;
      pc_write_en_c    = 1'b1;
      if_id_write_en_c = 1'b1;
      id_ex_bubble_c   = 1'b0;
      flush_if_id_c    = 1'b0;
      if (pipe_stall_c) begin
         pc_write_en_c    = 1'b0;
         if_id_write_en_c = 1'b0;
      end else if (hz.ex_branch_taken) begin
         id_ex_bubble_c = 1'b1;
         flush_if_id_c  = 1'b1;
      end else if (load_use_c) begin
         pc_write_en_c    = 1'b0;
         if_id_write_en_c = 1'b0;
         id_ex_bubble_c   = 1'b1;
      end
   end

   // Next state, wait counter, timeout and lost-cycle accounting.
   always_comb begin
      state_d        = state_q;
      wait_cnt_d     = wait_cnt_q;
      halted_d       = halted_q;
      mem_timeout_d  = mem_timeout_q;
      stall_cycles_d = stall_cycles_q;

      if ((state_q != HALTED) && (pipe_stall_c || id_ex_bubble_c) && (stall_cycles_q != STALL_MAX))
         stall_cycles_d = STALL_W'(stall_cycles_q + 1'b1);

      case (state_q)
         RUN: begin
            if (mem_miss_c) begin
               state_d    = MEM_WAIT;
               wait_cnt_d = '0;
            end else if (hz.halt_in) begin
               state_d  = HALTED;
               halted_d = 1'b1;
            end
         end
         MEM_WAIT: begin
            if (mem_miss_c) begin
               if (wait_cnt_q != WAIT_MAX) wait_cnt_d = WAIT_W'(wait_cnt_q + 1'b1);
               if (wait_cnt_d == WAIT_MAX) mem_timeout_d = 1'b1;
            end else if (hz.halt_in) begin
               state_d  = HALTED;
               halted_d = 1'b1;
            end else begin
               state_d = RUN;
            end
         end
         HALTED:  state_d = HALTED;
         default: state_d = RUN;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q        <= RUN;
         wait_cnt_q     <= '0;
         halted_q       <= 1'b0;
         mem_timeout_q  <= 1'b0;
         stall_cycles_q <= '0;
      end else begin
         state_q        <= state_d;
         wait_cnt_q     <= wait_cnt_d;
         halted_q       <= halted_d;
         mem_timeout_q  <= mem_timeout_d;
         stall_cycles_q <= stall_cycles_d;
      end
   end

   assign hz.pipe_stall     = pipe_stall_c;
   assign hz.pc_write_en    = pc_write_en_c;
   assign hz.if_id_write_en = if_id_write_en_c;
   assign hz.id_ex_bubble   = id_ex_bubble_c;
   assign hz.flush_if_id    = flush_if_id_c;
   assign hz.halted         = halted_q;
   assign hz.mem_timeout    = mem_timeout_q;
   assign hz.stall_cycles   = stall_cycles_q;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: directed scenarios plus random traffic checked
// against a cycle-level behavioural model of the hazard rules.
module tb_pipeline_hazard_ctrl;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   pipeline_hazard_ctrl_if hz();
   pipeline_hazard_ctrl dut (.clk(clk), .reset(rst), .hz(hz));

   typedef struct {
      logic       rst;
      logic [4:0] rs, rt, dst;
      logic       urt, emr, br, mreq, crdy, halt;
   } stim_t;

   typedef struct {
      logic        stall, pc, ifid, bub, flush, halted, to;
      logic [15:0] sc;
   } exp_t;

   exp_t  sb[$];
   stim_t st;
   int    vectors = 0;
   int    miscompares = 0;
   bit    stim_done = 1'b0;

   // Behavioural model state
   bit m_halted, m_waiting, m_to;
   int m_wait, m_sc;

   function automatic stim_t idle_stim();
      stim_t s;
      s.rst = 1'b0; s.rs = '0; s.rt = '0; s.dst = '0;
      s.urt = 1'b0; s.emr = 1'b0; s.br = 1'b0; s.mreq = 1'b0; s.crdy = 1'b0; s.halt = 1'b0;
      return s;
   endfunction

   task automatic apply(input stim_t s);
      rst = s.rst;
      hz.id_rs = s.rs; hz.id_rt = s.rt; hz.id_uses_rt = s.urt;
      hz.ex_mem_read = s.emr; hz.ex_dst = s.dst; hz.ex_branch_taken = s.br;
      hz.mem_req = s.mreq; hz.cache_ready = s.crdy; hz.halt_in = s.halt;
   endtask

   // One clock cycle: drive stimulus, predict this cycle's outputs, advance the model.
   task automatic step();
      exp_t e;
      bit miss, lu;
      @(posedge clk); #1;
      apply(st);
      if (st.rst) begin
         m_halted = 0; m_waiting = 0; m_to = 0; m_wait = 0; m_sc = 0;
      end
      miss = st.mreq && !st.crdy;
      lu   = st.emr && (st.dst != 0) && ((st.dst == st.rs) || (st.urt && (st.dst == st.rt)));
      e.halted = m_halted; e.to = m_to; e.sc = 16'(m_sc);
      e.stall = 0; e.pc = 0; e.ifid = 0; e.bub = 0; e.flush = 0;
      if (m_halted || miss)  e.stall = 1;
      else if (st.br)        begin e.pc = 1; e.ifid = 1; e.flush = 1; e.bub = 1; end
      else if (lu)           e.bub = 1;
      else                   begin e.pc = 1; e.ifid = 1; end
      sb.push_back(e);
      if (!st.rst && !m_halted) begin
         if ((e.stall || e.bub) && m_sc < 65535) m_sc++;
         if (miss) begin
            if (m_waiting) begin
               if (m_wait < 255) m_wait++;
               if (m_wait == 255) m_to = 1;
            end else begin
               m_waiting = 1; m_wait = 0;
            end
         end else begin
            m_waiting = 0;
            if (st.halt) m_halted = 1;
         end
      end
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
      end
   endtask

   // Monitor: pop expectations and compare against the DUT away from the active edge.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            vectors++;
            chk("pipe_stall",     16'(hz.pipe_stall),     16'(e.stall));
            chk("pc_write_en",    16'(hz.pc_write_en),    16'(e.pc));
            chk("if_id_write_en", 16'(hz.if_id_write_en), 16'(e.ifid));
            chk("id_ex_bubble",   16'(hz.id_ex_bubble),   16'(e.bub));
            chk("flush_if_id",    16'(hz.flush_if_id),    16'(e.flush));
            chk("halted",         16'(hz.halted),         16'(e.halted));
            chk("mem_timeout",    16'(hz.mem_timeout),    16'(e.to));
            chk("stall_cycles",   hz.stall_cycles,        e.sc);
         end
      end
   end

   initial begin
      st = idle_stim();
      st.rst = 1'b1;
      apply(st);
      m_halted = 0; m_waiting = 0; m_to = 0; m_wait = 0; m_sc = 0;
      steps(2);
      st.rst = 1'b0; steps(2);

      // Load-use on rs: a single bubble
      st.emr = 1; st.dst = 5'd5; st.rs = 5'd5; step();
      st = idle_stim(); steps(2);
      // Load-use via rt only when rt is used
      st.emr = 1; st.dst = 5'd7; st.rt = 5'd7; st.urt = 0; step();
      st.urt = 1; step();
      st = idle_stim(); step();

      // Four-cycle cache miss then ready
      st.mreq = 1; st.crdy = 0; steps(4);
      st.crdy = 1; step();
      st = idle_stim(); steps(2);

      // Miss + branch + load-use, then branch alone after the miss drops
      st.emr = 1; st.dst = 5'd9; st.rs = 5'd9; st.br = 1; st.mreq = 1; st.crdy = 0; steps(2);
      st.crdy = 1; step();
      st = idle_stim(); step();

      // Zero register never hazards
      st.emr = 1; st.dst = 5'd0; st.rs = 5'd0; st.rt = 5'd0; st.urt = 1; step();
      st = idle_stim(); step();

      // Long miss trips the timeout; sticky until reset
      st.mreq = 1; st.crdy = 0; steps(300);
      st = idle_stim(); steps(5);
      st.rst = 1; step();
      st.rst = 0; steps(2);

      // Halt during a stall is deferred to the release cycle
      st.mreq = 1; st.crdy = 0; st.halt = 1; steps(3);
      st.crdy = 1; step();
      st = idle_stim(); st.br = 1; st.emr = 1; st.dst = 5'd3; st.rs = 5'd3; steps(3);
      st = idle_stim(); steps(2);
      st.rst = 1; step();
      st.rst = 0; steps(2);

      // Reset mid-MEM_WAIT abandons the wait
      st.mreq = 1; st.crdy = 0; steps(5);
      st = idle_stim(); st.rst = 1; step();
      st.rst = 0; steps(2);

      // Random traffic with dense register collisions
      for (int i = 0; i < 2000; i++) begin
         st.rst  = ($urandom_range(0, 199) == 0);
         st.rs   = 5'($urandom_range(0, 3));
         st.rt   = 5'($urandom_range(0, 3));
         st.dst  = 5'($urandom_range(0, 3));
         st.urt  = 1'($urandom_range(0, 1));
         st.emr  = 1'($urandom_range(0, 1));
         st.br   = ($urandom_range(0, 4) == 0);
         st.mreq = 1'($urandom_range(0, 1));
         st.crdy = ($urandom_range(0, 2) != 0);
         st.halt = ($urandom_range(0, 299) == 0);
         step();
      end
      st = idle_stim(); st.rst = 1; step();
      st.rst = 0; step();

      // Saturation of the lost-cycle counter via a very long miss
      st.mreq = 1; st.crdy = 0; steps(65600);
      st = idle_stim(); step();
      st.emr = 1; st.dst = 5'd4; st.rs = 5'd4; steps(2);
      st = idle_stim(); st.br = 1; step();
      st = idle_stim(); steps(2);

      stim_done = 1'b1;
      @(negedge clk); @(negedge clk);
      if (sb.size() != 0) begin
         miscompares++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 The block SHALL have the following ports, with the clock and reset first; the block uses one clock, and reset is asynchronous and active-high.
- clk  in  1  sole clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- id_rs  in  5  source register 1 of the instruction in ID.
- id_rt  in  5  source register 2 of the instruction in ID.
- id_uses_rt  in  1  ID instruction reads id_rt.
- ex_mem_read  in  1  EX instruction is a load (is_mem_inst and mem_to_reg from the ID/EX register).
- ex_dst  in  5  destination register of the EX instruction.
- ex_branch_taken  in  1  EX resolved a taken branch or jump this cycle.
- mem_req  in  1  MEM stage holds a valid cache access this cycle.
- cache_ready  in  1  cache completes the MEM access this cycle.
- halt_in  in  1  halt instruction reached WB.
- pipe_stall  out  1  holds every pipeline register; drives the cache_done hold input of ID/EX and the other stage registers.
- pc_write_en  out  1  PC update enable.
- if_id_write_en  out  1  IF/ID register load enable.
- id_ex_bubble  out  1  loads a NOP (all control bits 0) into ID/EX.
- flush_if_id  out  1  clears IF/ID to a NOP.
- halted  out  1  core halted.
- mem_timeout  out  1  sticky flag: a cache wait exceeded 255 cycles.
- stall_cycles  out  16  saturating count of lost cycles.

Function
REQ-002 The FSM SHALL have three states: RUN, MEM_WAIT and HALTED; the encoding is free.
REQ-003 The outputs pipe_stall, pc_write_en, if_id_write_en, id_ex_bubble and flush_if_id SHALL be combinational functions of the state and the current inputs; halted, mem_timeout and stall_cycles SHALL be registered.
REQ-004 mem_miss SHALL equal mem_req AND NOT cache_ready.
- In RUN and MEM_WAIT, pipe_stall SHALL equal mem_miss.
- In HALTED, pipe_stall SHALL be 1.
REQ-005 RUN to MEM_WAIT SHALL occur on mem_miss; MEM_WAIT to RUN SHALL occur on the first cycle with NOT mem_miss; the release cycle is unstalled.
REQ-006 An 8-bit wait counter SHALL work as follows:
- Cleared on entry to MEM_WAIT.
- Increments each MEM_WAIT cycle.
- Reaching 255 sets mem_timeout.
- mem_timeout clears only on reset.
- The stall is still honoured after timeout.
REQ-007 load_use SHALL equal ex_mem_read AND ex_dst != 0 AND (ex_dst == id_rs OR (id_uses_rt AND ex_dst == id_rt)).
REQ-008 Output priority SHALL be HALTED > pipe_stall > ex_branch_taken > load_use > normal.
REQ-009 In HALTED or when pipe_stall = 1, the outputs SHALL be: pc_write_en = 0, if_id_write_en = 0, id_ex_bubble = 0, flush_if_id = 0.
REQ-010 For a taken branch, the outputs SHALL be: pc_write_en = 1, if_id_write_en = 1, flush_if_id = 1, id_ex_bubble = 1; any simultaneous load_use is ignored.
REQ-011 For load_use, the outputs SHALL be: pc_write_en = 0, if_id_write_en = 0, id_ex_bubble = 1, flush_if_id = 0; this gives exactly one bubble per load-use hazard, because the load leaves EX on the next edge.
REQ-012 In the normal case, the outputs SHALL be: pc_write_en = 1, if_id_write_en = 1, id_ex_bubble = 0, flush_if_id = 0.
REQ-013 halt_in SHALL take effect as follows:
- Sampled only when the state is not HALTED and pipe_stall = 0.
- It moves the FSM to HALTED and sets halted = 1 on the next edge.
- If halt_in coincides with pipe_stall = 1, it is ignored that cycle; WB holds it, so it is taken on the release cycle.
REQ-014 HALTED SHALL be left only by reset.
REQ-015 stall_cycles SHALL increment on every edge where pipe_stall OR id_ex_bubble is 1 and the state is not HALTED; it saturates at 0xFFFF and never wraps.
REQ-016 ex_dst = 0 SHALL never create a hazard.

Reset
REQ-017 Asserting reset SHALL immediately force:
- state RUN, wait counter 0, halted 0, mem_timeout 0, stall_cycles 0.
- The combinational outputs follow the RUN equations, e.g. with all inputs 0: pc_write_en = 1, if_id_write_en = 1, all others 0.
REQ-018 Reset asserted mid-MEM_WAIT or in HALTED SHALL abandon that state with no residual stall after deassertion, unless mem_miss is still present.

Verification
REQ-019 Load-use: ex_mem_read = 1, ex_dst = 5, id_rs = 5 for one cycle -> id_ex_bubble = 1, pc_write_en = 0, if_id_write_en = 0 for that cycle only; stall_cycles = 1.
REQ-020 Cache miss: mem_req = 1 with cache_ready = 0 for 4 cycles, then 1 -> pipe_stall = 1 for exactly 4 cycles and 0 on the ready cycle; stall_cycles = 4; state back to RUN.
REQ-021 Priority: load_use, ex_branch_taken and mem_miss together -> only pipe_stall = 1; when mem_miss drops with the branch still taken -> flush_if_id = 1, id_ex_bubble = 1, pc_write_en = 1.
REQ-022 Timeout: mem_miss held 300 cycles -> mem_timeout rises after 255 MEM_WAIT cycles and stays 1 after the miss ends; cleared only by reset.
REQ-023 Halt: halt_in = 1 during a stall -> halted stays 0; halted rises one edge after the stall releases; thereafter pipe_stall = 1 and pc_write_en = 0 regardless of inputs, until reset.
REQ-024 Zero register and saturation: ex_dst = 0 = id_rs with ex_mem_read = 1 -> no bubble; stall_cycles preloaded near 0xFFFF via a long miss -> holds at 0xFFFF.
